// File: rtl/data_mem_responder.sv
// Slave-port responder: turns interconnect req/gnt/rvalid handshakes into
// single-port SRAM accesses, with optional wait states before the response.
module data_mem_responder #(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned SLAVE_ADDR_WIDTH = 10,
   parameter int unsigned MEM_ADDR_WIDTH   = SLAVE_ADDR_WIDTH - 2,
   parameter int unsigned WAIT_STATES      = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        slave_data_req_i,
   input  logic [SLAVE_ADDR_WIDTH-1:0] slave_data_addr_i,
   input  logic                        slave_data_we_i,
   input  logic [DATA_WIDTH/8-1:0]     slave_data_be_i,
   input  logic [DATA_WIDTH-1:0]       slave_data_wdata_i,
   output logic [DATA_WIDTH-1:0]       slave_data_rdata_o,
   output logic                        slave_data_rvalid_o,
   output logic                        slave_data_gnt_o,
   output logic                        mem_csb_o,
   output logic                        mem_web_o,
   output logic [DATA_WIDTH/8-1:0]     mem_wmask_o,
   output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]       mem_din_o,
   input  logic [DATA_WIDTH-1:0]       mem_dout_i
);
   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH = 4;
   localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
      (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;

   if (WAIT_STATES > 15) begin : g_bad_wait_states
      $error("data_mem_responder: WAIT_STATES must be in 0..15");
   end
   if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
      $error("data_mem_responder: DATA_WIDTH must be a multiple of 8");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
   logic                      first_wait_q, first_wait_d;
   logic                      is_read_q, is_read_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     din_q, din_d;
   logic                      gnt;

   // Byte offset within the word is not used by a word-wide SRAM.
   logic [1:0] unused_addr_lsb;
   assign unused_addr_lsb = slave_data_addr_i[1:0];

   // Next-state, SRAM access and response decode.
   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      first_wait_d        = 1'b0;
      is_read_d           = is_read_q;
      rdata_d             = rdata_q;
      addr_d              = addr_q;
      din_d               = din_q;
      gnt                 = 1'b0;
      mem_csb_o           = 1'b1;
      mem_web_o           = 1'b1;
      mem_wmask_o         = '0;
      slave_data_rvalid_o = 1'b0;
      slave_data_rdata_o  = '0;

      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (state_q == ST_RESP) begin
               slave_data_rvalid_o = 1'b1;
               if (is_read_q) begin
                  slave_data_rdata_o = (WAIT_STATES == 0) ? mem_dout_i : rdata_q;
               end
            end
            gnt = slave_data_req_i & ~reset;
            if (gnt) begin
               mem_csb_o   = 1'b0;
               mem_web_o   = ~slave_data_we_i;
               mem_wmask_o = slave_data_we_i ? slave_data_be_i : BE_WIDTH'(0);
               addr_d      = MEM_ADDR_WIDTH'(slave_data_addr_i[SLAVE_ADDR_WIDTH-1:2]);
               din_d       = slave_data_wdata_i;
               is_read_d   = ~slave_data_we_i;
               if (WAIT_STATES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d      = ST_WAIT;
                  cnt_d        = CNT_LOAD;
                  first_wait_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // SRAM output is only guaranteed the cycle right after the access.
            if (first_wait_q && is_read_q) begin
               rdata_d = mem_dout_i;
            end
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign slave_data_gnt_o = gnt;
   assign mem_addr_o       = addr_d;
   assign mem_din_o        = din_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         first_wait_q <= 1'b0;
         is_read_q    <= 1'b0;
         rdata_q      <= '0;
         addr_q       <= '0;
         din_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         first_wait_q <= first_wait_d;
         is_read_q    <= is_read_d;
         rdata_q      <= rdata_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: five instances with different wait-state
// counts, each backed by an SRAM model and checked against a scoreboard.
module tb_data_mem_responder;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 10;
   localparam int unsigned MW = 8;
   localparam int unsigned BW = 4;
   localparam int NI = 5;
   localparam logic [DW-1:0] STALE = 32'hDEAD_0BAD;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } sb_t;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic mon_en = 1'b0;
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic          req_a    [NI];
   logic [AW-1:0] addr_a   [NI];
   logic          we_a     [NI];
   logic [BW-1:0] be_a     [NI];
   logic [DW-1:0] wdata_a  [NI];
   logic [DW-1:0] rdata_a  [NI];
   logic          rvalid_a [NI];
   logic          gnt_a    [NI];
   logic          csb_a    [NI];
   logic          web_a    [NI];
   logic [BW-1:0] wmask_a  [NI];
   logic [MW-1:0] maddr_a  [NI];
   logic [DW-1:0] din_a    [NI];
   logic [DW-1:0] dout_a   [NI];
   int            n_gnt    [NI];
   int            n_rv     [NI];
   int            q_len    [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 3 : 5;
      logic [DW-1:0] sram    [2**MW] = '{default: '0};
      logic [DW-1:0] ref_mem [2**MW] = '{default: '0};
      sb_t           q [$];

      data_mem_responder #(
         .DATA_WIDTH(DW), .SLAVE_ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW), .WAIT_STATES(WS)
      ) u_dut (
         .clk(clk), .reset(reset),
         .slave_data_req_i(req_a[g]), .slave_data_addr_i(addr_a[g]),
         .slave_data_we_i(we_a[g]), .slave_data_be_i(be_a[g]),
         .slave_data_wdata_i(wdata_a[g]), .slave_data_rdata_o(rdata_a[g]),
         .slave_data_rvalid_o(rvalid_a[g]), .slave_data_gnt_o(gnt_a[g]),
         .mem_csb_o(csb_a[g]), .mem_web_o(web_a[g]), .mem_wmask_o(wmask_a[g]),
         .mem_addr_o(maddr_a[g]), .mem_din_o(din_a[g]), .mem_dout_i(dout_a[g])
      );

      // SRAM macro model: read data is only meaningful the cycle after a read.
      always @(posedge clk) begin
         dout_a[g] <= STALE;
         if (csb_a[g] === 1'b0) begin
            if (web_a[g] === 1'b0) begin
               for (int b = 0; b < int'(BW); b++)
                  if (wmask_a[g][b]) sram[maddr_a[g]][b*8 +: 8] <= din_a[g][b*8 +: 8];
            end else begin
               dout_a[g] <= sram[maddr_a[g]];
            end
         end
      end

      // Scoreboard: expected gnt/rvalid/rdata from an independent model.
      always @(negedge clk) begin
         logic          exp_gnt, exp_rv;
         logic [DW-1:0] exp_rd;
         int            w;
         if (mon_en) begin
            exp_rv  = (q.size() > 0) && (q[0].due == cyc);
            exp_rd  = '0;
            if (exp_rv) exp_rd = q[0].data;
            exp_gnt = req_a[g] && !reset && ((q.size() == 0) || exp_rv);
            n_cmp++;
            if (gnt_a[g] !== exp_gnt) begin
               n_err++;
               $display("FAIL sb_gnt ws=%0d cyc=%0d: got %b expected %b", WS, cyc, gnt_a[g], exp_gnt);
            end
            n_cmp++;
            if (rvalid_a[g] !== exp_rv) begin
               n_err++;
               $display("FAIL sb_rvalid ws=%0d cyc=%0d: got %b expected %b", WS, cyc, rvalid_a[g], exp_rv);
            end
            n_cmp++;
            if (rdata_a[g] !== exp_rd) begin
               n_err++;
               $display("FAIL sb_rdata ws=%0d cyc=%0d: got %h expected %h", WS, cyc, rdata_a[g], exp_rd);
            end
            if (rvalid_a[g] === 1'b1) n_rv[g]++;
            if (gnt_a[g] === 1'b1) n_gnt[g]++;
            if (exp_rv) void'(q.pop_front());
            if (exp_gnt) begin
               w = int'(addr_a[g][AW-1:2]);
               if (we_a[g]) begin
                  for (int b = 0; b < int'(BW); b++)
                     if (be_a[g][b]) ref_mem[w][b*8 +: 8] = wdata_a[g][b*8 +: 8];
                  q.push_back('{cyc + int'(WS) + 1, '0});
               end else begin
                  q.push_back('{cyc + int'(WS) + 1, ref_mem[w]});
               end
            end
            if (reset) q.delete();
            q_len[g] = q.size();
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         for (int k = 0; k < NI; k++) req_a[k] = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < NI; k++) begin
         req_a[k] = 1'b0; addr_a[k] = '0; we_a[k] = 1'b0; be_a[k] = '0; wdata_a[k] = '0;
         n_gnt[k] = 0; n_rv[k] = 0; q_len[k] = 0;
      end
      req_a[0] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         n_cmp++; if (gnt_a[k] !== 1'b0) begin n_err++; $display("FAIL reset_gnt[%0d]: got %b expected 0", k, gnt_a[k]); end
         n_cmp++; if (rvalid_a[k] !== 1'b0) begin n_err++; $display("FAIL reset_rvalid[%0d]: got %b expected 0", k, rvalid_a[k]); end
         n_cmp++; if (rdata_a[k] !== '0) begin n_err++; $display("FAIL reset_rdata[%0d]: got %h expected 0", k, rdata_a[k]); end
         n_cmp++; if (csb_a[k] !== 1'b1) begin n_err++; $display("FAIL reset_csb[%0d]: got %b expected 1", k, csb_a[k]); end
         n_cmp++; if (web_a[k] !== 1'b1) begin n_err++; $display("FAIL reset_web[%0d]: got %b expected 1", k, web_a[k]); end
         n_cmp++; if (wmask_a[k] !== '0) begin n_err++; $display("FAIL reset_wmask[%0d]: got %h expected 0", k, wmask_a[k]); end
         n_cmp++; if (maddr_a[k] !== '0) begin n_err++; $display("FAIL reset_addr[%0d]: got %h expected 0", k, maddr_a[k]); end
         n_cmp++; if (din_a[k] !== '0) begin n_err++; $display("FAIL reset_din[%0d]: got %h expected 0", k, din_a[k]); end
      end
      next_cycle();
      reset    = 1'b0;
      req_a[0] = 1'b0;
      mon_en   = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ws0();
      next_cycle();
      req_a[0] = 1'b1; we_a[0] = 1'b1; be_a[0] = 4'hF; addr_a[0] = 10'h010; wdata_a[0] = 32'hDEADBEEF;
      @(negedge clk);
      n_cmp++; if (gnt_a[0] !== 1'b1) begin n_err++; $display("FAIL ws0_gnt_wr: got %b expected 1", gnt_a[0]); end
      n_cmp++; if (maddr_a[0] !== 8'h04) begin n_err++; $display("FAIL ws0_addr_wr: got %h expected 04", maddr_a[0]); end
      n_cmp++; if (web_a[0] !== 1'b0 || csb_a[0] !== 1'b0) begin n_err++; $display("FAIL ws0_web_wr: got csb=%b web=%b expected 0 0", csb_a[0], web_a[0]); end
      n_cmp++; if (din_a[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL ws0_din: got %h expected deadbeef", din_a[0]); end
      next_cycle();
      we_a[0] = 1'b0;
      @(negedge clk);
      n_cmp++; if (gnt_a[0] !== 1'b1) begin n_err++; $display("FAIL ws0_gnt_rd: got %b expected 1", gnt_a[0]); end
      n_cmp++; if (web_a[0] !== 1'b1 || maddr_a[0] !== 8'h04) begin n_err++; $display("FAIL ws0_rd_access: got web=%b addr=%h expected 1 04", web_a[0], maddr_a[0]); end
      n_cmp++; if (wmask_a[0] !== 4'h0) begin n_err++; $display("FAIL ws0_rd_wmask: got %h expected 0", wmask_a[0]); end
      n_cmp++; if (rvalid_a[0] !== 1'b1 || rdata_a[0] !== '0) begin n_err++; $display("FAIL ws0_wr_resp: got rvalid=%b rdata=%h expected 1 0", rvalid_a[0], rdata_a[0]); end
      next_cycle();
      req_a[0] = 1'b0; addr_a[0] = 10'h3F0; wdata_a[0] = 32'h12345678;
      @(negedge clk);
      n_cmp++; if (rvalid_a[0] !== 1'b1 || rdata_a[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL ws0_rd_resp: got rvalid=%b rdata=%h expected 1 deadbeef", rvalid_a[0], rdata_a[0]); end
      n_cmp++; if (csb_a[0] !== 1'b1 || maddr_a[0] !== 8'h04 || din_a[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL ws0_hold: got csb=%b addr=%h din=%h expected 1 04 deadbeef", csb_a[0], maddr_a[0], din_a[0]); end
      idle_cycles(2);
   endtask

   task automatic test_partial();
      next_cycle();
      req_a[0] = 1'b1; we_a[0] = 1'b1; be_a[0] = 4'hF; addr_a[0] = 10'h020; wdata_a[0] = 32'h11223344;
      @(negedge clk);
      n_cmp++; if (gnt_a[0] !== 1'b1) begin n_err++; $display("FAIL partial_gnt1: got %b expected 1", gnt_a[0]); end
      next_cycle();
      be_a[0] = 4'b0100; wdata_a[0] = 32'hAABBCCDD;
      @(negedge clk);
      n_cmp++; if (wmask_a[0] !== 4'b0100 || web_a[0] !== 1'b0) begin n_err++; $display("FAIL partial_wmask: got wmask=%b web=%b expected 0100 0", wmask_a[0], web_a[0]); end
      next_cycle();
      we_a[0] = 1'b0; be_a[0] = 4'h0;
      @(negedge clk);
      n_cmp++; if (gnt_a[0] !== 1'b1) begin n_err++; $display("FAIL partial_gnt_rd: got %b expected 1", gnt_a[0]); end
      next_cycle();
      req_a[0] = 1'b0;
      @(negedge clk);
      n_cmp++; if (rvalid_a[0] !== 1'b1 || rdata_a[0] !== 32'h11BB3344) begin n_err++; $display("FAIL partial_rdata: got rvalid=%b rdata=%h expected 1 11bb3344", rvalid_a[0], rdata_a[0]); end
      idle_cycles(2);
   endtask

   task automatic test_ws3();
      logic [13:0] gm, rm;
      next_cycle();
      req_a[3] = 1'b1; we_a[3] = 1'b1; be_a[3] = 4'hF; addr_a[3] = 10'h040; wdata_a[3] = 32'hCAFE0003;
      @(negedge clk);
      n_cmp++; if (gnt_a[3] !== 1'b1) begin n_err++; $display("FAIL ws3_gnt_wr: got %b expected 1", gnt_a[3]); end
      idle_cycles(6);
      gm = '0; rm = '0;
      for (int i = 0; i < 14; i++) begin
         next_cycle();
         req_a[3] = (i < 10); we_a[3] = 1'b0; be_a[3] = 4'h0;
         @(negedge clk);
         if (gnt_a[3] === 1'b1) gm[i] = 1'b1;
         if (rvalid_a[3] === 1'b1) begin
            rm[i] = 1'b1;
            n_cmp++; if (rdata_a[3] !== 32'hCAFE0003) begin n_err++; $display("FAIL ws3_rdata cyc %0d: got %h expected cafe0003", i, rdata_a[3]); end
         end
      end
      n_cmp++; if (gm !== 14'h0111) begin n_err++; $display("FAIL ws3_gnt_pattern: got %b expected %b", gm, 14'h0111); end
      n_cmp++; if (rm !== 14'h1110) begin n_err++; $display("FAIL ws3_rvalid_pattern: got %b expected %b", rm, 14'h1110); end
      idle_cycles(2);
   endtask

   task automatic test_reset_mid();
      int rv_seen = 0;
      next_cycle();
      req_a[2] = 1'b1; we_a[2] = 1'b0; be_a[2] = 4'h0; addr_a[2] = 10'h2A8; wdata_a[2] = 32'h77;
      @(negedge clk);
      n_cmp++; if (gnt_a[2] !== 1'b1 || maddr_a[2] !== 8'hAA) begin n_err++; $display("FAIL rstmid_accept: got gnt=%b addr=%h expected 1 aa", gnt_a[2], maddr_a[2]); end
      next_cycle();
      req_a[2] = 1'b0; reset = 1'b1;
      @(negedge clk);
      if (rvalid_a[2] === 1'b1) rv_seen++;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      if (rvalid_a[2] === 1'b1) rv_seen++;
      n_cmp++; if (csb_a[2] !== 1'b1 || web_a[2] !== 1'b1 || wmask_a[2] !== '0) begin n_err++; $display("FAIL rstmid_ctrl: got csb=%b web=%b wmask=%h expected 1 1 0", csb_a[2], web_a[2], wmask_a[2]); end
      n_cmp++; if (maddr_a[2] !== '0 || din_a[2] !== '0) begin n_err++; $display("FAIL rstmid_hold_regs: got addr=%h din=%h expected 0 0", maddr_a[2], din_a[2]); end
      n_cmp++; if (rdata_a[2] !== '0 || gnt_a[2] !== 1'b0) begin n_err++; $display("FAIL rstmid_resp: got rdata=%h gnt=%b expected 0 0", rdata_a[2], gnt_a[2]); end
      next_cycle();
      req_a[2] = 1'b1; addr_a[2] = 10'h004;
      @(negedge clk);
      if (rvalid_a[2] === 1'b1) rv_seen++;
      n_cmp++; if (gnt_a[2] !== 1'b1) begin n_err++; $display("FAIL rstmid_regnt: got %b expected 1", gnt_a[2]); end
      n_cmp++; if (rv_seen !== 0) begin n_err++; $display("FAIL rstmid_dropped: got %0d rvalid expected 0", rv_seen); end
      idle_cycles(5);
   endtask

   task automatic test_addr_boundary();
      next_cycle();
      req_a[0] = 1'b1; we_a[0] = 1'b1; be_a[0] = 4'hF; addr_a[0] = 10'h3FF; wdata_a[0] = 32'h5A5AA5A5;
      @(negedge clk);
      n_cmp++; if (maddr_a[0] !== 8'hFF) begin n_err++; $display("FAIL bound_wr_addr: got %h expected ff", maddr_a[0]); end
      next_cycle();
      we_a[0] = 1'b0; addr_a[0] = 10'h3FC;
      @(negedge clk);
      n_cmp++; if (maddr_a[0] !== 8'hFF || gnt_a[0] !== 1'b1) begin n_err++; $display("FAIL bound_rd_addr: got addr=%h gnt=%b expected ff 1", maddr_a[0], gnt_a[0]); end
      next_cycle();
      req_a[0] = 1'b0;
      @(negedge clk);
      n_cmp++; if (rdata_a[0] !== 32'h5A5AA5A5) begin n_err++; $display("FAIL bound_rdata: got %h expected 5a5aa5a5", rdata_a[0]); end
      idle_cycles(2);
   endtask

   task automatic test_random();
      int ks [3] = '{0, 1, 4};
      int g0 [3];
      int r0 [3];
      int total;
      for (int j = 0; j < 3; j++) begin g0[j] = n_gnt[ks[j]]; r0[j] = n_rv[ks[j]]; end
      for (int i = 0; i < 12000; i++) begin
         next_cycle();
         foreach (ks[j]) begin
            req_a[ks[j]]   = ($urandom_range(0, 3) != 0);
            we_a[ks[j]]    = 1'($urandom_range(0, 1));
            be_a[ks[j]]    = 4'($urandom);
            addr_a[ks[j]]  = 10'($urandom_range(0, 63)) | (($urandom_range(0, 7) == 0) ? 10'h3C0 : 10'h000);
            wdata_a[ks[j]] = $urandom;
         end
         @(negedge clk);
      end
      idle_cycles(8);
      total = 0;
      for (int j = 0; j < 3; j++) begin
         total += n_gnt[ks[j]] - g0[j];
         n_cmp++; if ((n_gnt[ks[j]] - g0[j]) !== (n_rv[ks[j]] - r0[j])) begin n_err++; $display("FAIL rand_count inst %0d: got %0d rvalid expected %0d", ks[j], n_rv[ks[j]] - r0[j], n_gnt[ks[j]] - g0[j]); end
         n_cmp++; if (q_len[ks[j]] !== 0) begin n_err++; $display("FAIL rand_drain inst %0d: got %0d pending expected 0", ks[j], q_len[ks[j]]); end
      end
      n_cmp++; if (total < 10000) begin n_err++; $display("FAIL rand_volume: got %0d transactions expected at least 10000", total); end
   endtask

   initial begin
      test_reset();
      test_ws0();
      test_partial();
      test_ws3();
      test_reset_mid();
      test_addr_boundary();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Slave-side responder for one slave port of the data interconnect.
- Accepts req/addr/we/be/wdata transactions and returns gnt, rvalid and rdata on the same handshake the interconnect forwards to masters.
- Backs the port with a single-port synchronous SRAM macro: active-low chip select and write enable, 1-cycle read latency.
- Configurable wait states let slow macros or clock-ratio constraints be absorbed without changing the interconnect.

Parameters:
DATA_WIDTH, 32, data bus width; must be a multiple of 8
SLAVE_ADDR_WIDTH, 10, byte address width seen on the slave port
MEM_ADDR_WIDTH, SLAVE_ADDR_WIDTH-2, SRAM word address width
WAIT_STATES, 0, extra cycles between SRAM access and rvalid; legal range 0..15

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
slave_data_req_i  input  1  request from interconnect
slave_data_addr_i  input  SLAVE_ADDR_WIDTH  byte address
slave_data_we_i  input  1  1=write, 0=read
slave_data_be_i  input  DATA_WIDTH/8  byte enables
slave_data_wdata_i  input  DATA_WIDTH  write data
slave_data_rdata_o  output  DATA_WIDTH  read data, valid with rvalid
slave_data_rvalid_o  output  1  response valid, one cycle per accepted request
slave_data_gnt_o  output  1  request accepted this cycle
mem_csb_o  output  1  SRAM chip select, active low
mem_web_o  output  1  SRAM write enable, active low
mem_wmask_o  output  DATA_WIDTH/8  SRAM byte write mask
mem_addr_o  output  MEM_ADDR_WIDTH  SRAM word address
mem_din_o  output  DATA_WIDTH  SRAM write data
mem_dout_i  input  DATA_WIDTH  SRAM read data, valid the cycle after a read access

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset is sampled only on a clk rising edge.
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: wait-state countdown after an access.
  - RESP: rvalid asserted.
- Reset values:
  - State IDLE, wait counter 0, rdata capture register 0.
  - slave_data_gnt_o=0, slave_data_rvalid_o=0, slave_data_rdata_o=0.
  - mem_csb_o=1, mem_web_o=1, mem_wmask_o=0, mem_addr_o=0, mem_din_o=0.
- Acceptance:
  - gnt_o = req_i & (state==IDLE | state==RESP) & ~reset. It is combinational, so gnt falls in the same cycle req is seen.
  - In the accept cycle the SRAM access is issued combinationally:
    - csb=0; web=~we_i.
    - wmask = we_i ? be_i : 0.
    - addr = addr_i[SLAVE_ADDR_WIDTH-1:2]; din = wdata_i.
  - addr_i[1:0] is ignored. A write with be=0 still completes and still gets rvalid.
  - No accept cycle: csb=1, web=1, wmask=0. addr and din hold their last value.
- The write/read type of the accepted request is registered (is_read_q) for the response phase.
- Transitions:
  - IDLE or RESP with gnt:
    - WAIT_STATES==0 -> RESP.
    - WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - IDLE or RESP without gnt -> IDLE.
  - WAIT: in the first WAIT cycle, mem_dout_i is captured into rdata_q (reads only). Counter==0 -> RESP, else decrement.
- Latency:
  - rvalid asserts exactly WAIT_STATES+1 cycles after the gnt cycle, for exactly one cycle per accepted request, for both reads and writes.
  - Back-to-back accept in RESP gives throughput of one transaction per WAIT_STATES+1 cycles. With WAIT_STATES=0 this is one per cycle.
- Read data:
  - In RESP with is_read_q=1: rdata_o = (WAIT_STATES==0) ? mem_dout_i : rdata_q. The full word is returned regardless of be.
  - In RESP with a write, and in every non-RESP cycle, rdata_o = 0.
- Ordering:
  - Responses are in acceptance order; at most one transaction is outstanding.
  - A read following a write to the same word returns the new data, because the SRAM is single-port and the accesses are sequential.
- Boundary conditions:
  - req deasserted while in WAIT: no effect. req asserted in WAIT: no gnt; the master holds the request.
  - Reset mid-transaction: the pending response is dropped with no rvalid. The FSM is in IDLE in the cycle after the reset edge.
  - Maximum address 2^SLAVE_ADDR_WIDTH-1 maps to word 2^MEM_ADDR_WIDTH-1; there is no wrap or error response.
- Illegal configuration: WAIT_STATES>15 or DATA_WIDTH%8!=0 is rejected at elaboration.

Test Plan:
- WAIT_STATES=0:
  - Stimulus: write addr 0x010, be=4'hF, wdata 0xDEADBEEF, then a read of addr 0x010 on the next cycle.
  - Required response: gnt in both cycles, mem_addr=0x004, web=0 then 1. rvalid in cycles +1 and +2; second rdata=0xDEADBEEF, first (write response) rdata=0.
- Partial write:
  - Stimulus: write 0x11223344 to word 0x08, then write be=4'b0100, wdata 0xAABBCCDD to the same word, then read it.
  - Required response: wmask=4'b0100 on the second write; read returns 0x11BB3344.
- WAIT_STATES=3:
  - Stimulus: read req held high continuously.
  - Required response: gnt at cycles 0, 4, 8; rvalid at cycles 4, 8, 12; no gnt in WAIT cycles; rdata matches the SRAM model captured at cycles 1, 5, 9.
- Reset mid-operation:
  - Stimulus: WAIT_STATES=2, read accepted at cycle 0, reset asserted at cycle 1.
  - Required response: no rvalid ever for that read. All outputs at reset values after the cycle-1 edge; first gnt possible at cycle 2 after reset drops.
- Address boundary:
  - Stimulus: write addr 0x3FF then read addr 0x3FC (SLAVE_ADDR_WIDTH=10).
  - Required response: both map to mem_addr=0xFF; read returns the written data.
- Random:
  - Stimulus: 10k random req/we/be/addr transactions with a reference SRAM model, WAIT_STATES in {0,1,5}.
  - Required response: exactly one rvalid per gnt, in order, at gnt+WAIT_STATES+1; read data equals the model.
